// File: rtl/uart_instruction_sender_pkg.sv
// rtl/uart_instruction_sender_pkg.sv - shared types and defaults for the instruction UART link
// Shared with the instruction receiver.
package uart_instruction_sender_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int DEFAULT_BAUD_DIVIDER = 434;
   localparam int DEFAULT_DATA_BITS    = 15;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_instruction_sender_baud_tick.sv
// rtl/uart_instruction_sender_baud_tick.sv - bit-period counter with one-cycle terminal tick
// Counts 0..BAUD_DIVIDER and wraps; i_clear restarts a bit period.
module uart_baud_tick
   import uart_instruction_sender_pkg::*;
#(
   parameter int BAUD_DIVIDER = DEFAULT_BAUD_DIVIDER
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   output logic o_tick
);

   localparam int              CW          = width_of(BAUD_DIVIDER + 1);
   localparam logic [CW-1:0]   LP_TERMINAL = CW'(BAUD_DIVIDER);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_count <= '0;
      end else if (r_count == LP_TERMINAL) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_tick = (r_count == LP_TERMINAL);

endmodule

// File: rtl/uart_instruction_sender.sv
// rtl/uart_instruction_sender.sv - serialises one instruction word per UART frame
// Frame: start, DATA_BITS LSB first, optional even parity, STOP_BITS stop bits.
module uart_instruction_sender
   import uart_instruction_sender_pkg::*;
#(
   parameter int DATA_BITS    = DEFAULT_DATA_BITS,
   parameter int BAUD_DIVIDER = DEFAULT_BAUD_DIVIDER,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] instr_in,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int            BW           = width_of(DATA_BITS);
   localparam logic [BW-1:0] LP_LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          LP_LAST_STOP = (STOP_BITS == 2);

   state_t               r_state;
   state_t               w_state_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [BW-1:0]        r_bit_cnt;
   logic                 r_stop_cnt;
   logic                 r_parity;
   logic                 r_frame_done;
   logic                 w_tick;
   logic                 w_accept;
   logic                 w_baud_clear;
   logic                 w_last_data;
   logic                 w_last_stop;

   assign w_accept     = (r_state == IDLE) && instr_valid;
   assign w_baud_clear = (r_state == IDLE);
   assign w_last_data  = (r_bit_cnt == LP_LAST_BIT);
   assign w_last_stop  = (r_stop_cnt == LP_LAST_STOP);

   // Held clear while idle so the start bit always gets a full period.
   uart_baud_tick #(
      .BAUD_DIVIDER(BAUD_DIVIDER)
   ) u_baud_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clear(w_baud_clear),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (instr_valid) w_state_next = START;
         START:   if (w_tick) w_state_next = DATA;
         DATA:    if (w_tick && w_last_data) w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY:  if (w_tick) w_state_next = STOP;
         STOP:    if (w_tick && w_last_stop) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      instr_ready = (r_state == IDLE);
      busy        = (r_state != IDLE);
      tx          = 1'b1;
      case (r_state)
         START:   tx = 1'b0;
         DATA:    tx = r_shift[0];
         PARITY:  tx = r_parity;
         default: tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_stop_cnt   <= 1'b0;
         r_parity     <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= (r_state == STOP) && w_tick && w_last_stop;
         if (w_accept) begin
            r_shift    <= instr_in;
            r_parity   <= (PARITY_EN != 0) ? ^instr_in : 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
         end else if (w_tick) begin
            if (r_state == DATA) begin
               r_shift   <= r_shift >> 1;
               r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + BW'(1);
            end
            if (r_state == STOP) begin
               r_stop_cnt <= w_last_stop ? 1'b0 : 1'b1;
            end
         end
      end
   end

   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_instruction_sender.sv
// tb/tb_uart_instruction_sender.sv - randomized bench for uart_instruction_sender against a frame-level model
// Three instances cover no parity, even parity and two stop bits.
module tb_uart_instruction_sender;

   localparam int NI = 3;
   localparam int DB = 15;
   localparam int BD = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          instr_valid;
   logic [DB-1:0] instr_in;
   logic          tx_o   [NI];
   logic          busy_o [NI];
   logic          rdy_o  [NI];
   logic          fd_o   [NI];

   bit            m_act  [NI];
   int            m_cyc  [NI];
   logic [DB-1:0] m_word [NI];
   bit            m_fd   [NI];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   uart_instruction_sender #(.DATA_BITS(DB), .BAUD_DIVIDER(BD), .STOP_BITS(1), .PARITY_EN(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
      .instr_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]), .frame_done(fd_o[0]));
   uart_instruction_sender #(.DATA_BITS(DB), .BAUD_DIVIDER(BD), .STOP_BITS(1), .PARITY_EN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
      .instr_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]), .frame_done(fd_o[1]));
   uart_instruction_sender #(.DATA_BITS(DB), .BAUD_DIVIDER(BD), .STOP_BITS(2), .PARITY_EN(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
      .instr_ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]), .frame_done(fd_o[2]));

   function automatic int par_of(input int i);
      return (i == 1) ? 1 : 0;
   endfunction

   function automatic int stop_of(input int i);
      return (i == 2) ? 2 : 1;
   endfunction

   function automatic int frame_len(input int i);
      return (1 + DB + par_of(i) + stop_of(i)) * (BD + 1);
   endfunction

   // Line level expected at cycle cyc of a frame carrying word w.
   function automatic logic exp_bit(input int i, input logic [DB-1:0] w, input int cyc);
      int b;
      b = cyc / (BD + 1);
      if (b == 0) return 1'b0;
      if (b <= DB) return w[b-1];
      if (par_of(i) == 1 && b == DB + 1) return ($countones(w) % 2) == 1;
      return 1'b1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            m_act[i] <= 1'b0;
            m_fd[i]  <= 1'b0;
         end else if (m_act[i]) begin
            if (m_cyc[i] + 1 == frame_len(i)) begin
               m_act[i] <= 1'b0;
               m_fd[i]  <= 1'b1;
            end else begin
               m_cyc[i] <= m_cyc[i] + 1;
               m_fd[i]  <= 1'b0;
            end
         end else begin
            m_fd[i] <= 1'b0;
            if (instr_valid) begin
               m_act[i]  <= 1'b1;
               m_cyc[i]  <= 0;
               m_word[i] <= instr_in;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n !== 1'bx) begin
         for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("tx[%0d]", i), 32'(tx_o[i]),
                     32'(m_act[i] ? exp_bit(i, m_word[i], m_cyc[i]) : 1'b1));
            check_eq($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_act[i]));
            check_eq($sformatf("instr_ready[%0d]", i), 32'(rdy_o[i]), 32'(!m_act[i]));
            check_eq($sformatf("frame_done[%0d]", i), 32'(fd_o[i]), 32'(m_fd[i]));
         end
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         instr_in = DB'($urandom);
      end
   endtask

   task automatic send_pulse(input logic [DB-1:0] w);
      instr_in    = w;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      instr_in    = DB'($urandom);
   endtask

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b1;
      instr_in    = DB'($urandom);
      repeat (3) @(negedge clk);
      rst_n       = 1'b1;
      instr_valid = 1'b0;
      idle_cycles(4);

      send_pulse(15'h5A3C);
      idle_cycles(80);
      send_pulse(15'h0001);
      idle_cycles(80);

      instr_in    = 15'h7FFF;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_in    = 15'h0000;
      repeat (80) @(negedge clk);
      instr_valid = 1'b0;
      idle_cycles(160);

      send_pulse(DB'($urandom));
      idle_cycles(29);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send_pulse(DB'($urandom));
      idle_cycles(80);

      send_pulse(15'h2AAA);
      idle_cycles(80);

      repeat (2000) begin
         instr_valid = ($urandom % 4) != 0;
         instr_in    = DB'($urandom);
         rst_n       = ($urandom % 300) != 0;
         @(negedge clk);
      end
      rst_n       = 1'b1;
      instr_valid = 1'b0;
      idle_cycles(80);

      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
